// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath mux select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXEC_R  = 4'd6,
    ST_EXEC_I  = 4'd7,
    ST_ALU_WB  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JAL     = 4'd10,
    ST_TRAP    = 4'd11
  } state_e;

  // Instruction classes handed to the ALU decoder
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_SUB = 2'd1,
    CLS_R   = 2'd2,
    CLS_I   = 2'd3
  } alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_INC = 2'd2;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps instruction class, funct3 and funct7_5 to alu_ctrl.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  // funct7_5 selects SUB only for register ops; shifts honour it for both classes
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_class)
      CLS_SUB: alu_ctrl = ALU_SUB;
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-style main control FSM with configurable memory latency.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int PC_INCREMENT = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  output logic                  pc_write,
  output logic                  iord,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [3:0]            alu_ctrl,
  output logic [1:0]            result_src,
  output logic [DATA_WIDTH-1:0] pc_inc,
  output logic                  illegal,
  output logic [3:0]            state
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic [1:0] alu_class;
  logic       cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign pc_inc   = DATA_WIDTH'(PC_INCREMENT);
  assign state    = state_q;
  assign illegal  = illegal_q;

  alu_decoder u_alu_decoder (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_ctrl  (alu_ctrl)
  );

  // State, wait counter and sticky illegal flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, wait counter and control output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_class  = CLS_ADD;
    result_src = RES_ALUOUT;

    case (state_q)
      ST_FETCH: begin
        alu_src_b  = SRCB_INC;
        result_src = RES_ALU;
        if (cnt_last) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADR;
          OP_R:              state_d = ST_EXEC_R;
          OP_I:              state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LOAD)       state_d = ST_MEM_RD;
        else if (opcode == OP_STORE) state_d = ST_MEM_WR;
        else                         state_d = ST_TRAP;
      end
      ST_MEM_RD: begin
        iord = 1'b1;
        if (cnt_last) state_d = ST_MEM_WB;
        else          cnt_d   = cnt_q + 4'd1;
      end
      ST_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (cnt_last) state_d = ST_FETCH;
        else          cnt_d   = cnt_q + 4'd1;
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_class = CLS_R;
        state_d   = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_class = CLS_I;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_class = CLS_SUB;
        case (funct3)
          3'b000: begin pc_write = zero;  state_d = ST_FETCH; end
          3'b001: begin pc_write = !zero; state_d = ST_FETCH; end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_INC;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase

    illegal_d = illegal_q | (state_d == ST_TRAP);
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles each memory access (fetch, load, store) occupies; legal range 1..15.
REQ-002 Parameter PC_INCREMENT, default 4: not used by the FSM; passed through to `pc_inc` as a constant for datapath adder wiring.
REQ-003 Parameter DATA_WIDTH, default 32: datapath width; sets `pc_inc` width.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  7  instruction register bits [6:0].
REQ-007 funct3  input  3  instruction register bits [14:12].
REQ-008 funct7_5  input  1  instruction register bit 30.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 pc_write  output  1  PC register load enable.
REQ-011 iord  output  1  memory address mux select: 0 = PC, 1 = ALUOut.
REQ-012 mem_write  output  1  memory write strobe.
REQ-013 ir_write  output  1  instruction register load enable.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 alu_src_a  output  2  ALU A select: 0 = PC, 1 = old PC, 2 = rs1.
REQ-016 alu_src_b  output  2  ALU B select: 0 = rs2, 1 = immediate, 2 = PC_INCREMENT.
REQ-017 alu_ctrl  output  4  ALU operation code.
REQ-018 result_src  output  2  select: 0 = ALUOut, 1 = memory data, 2 = ALU result.
REQ-019 pc_inc  output  DATA_WIDTH  constant PC_INCREMENT.
REQ-020 illegal  output  1  sticky flag: unsupported opcode or funct3 decoded.
REQ-021 state  output  4  current FSM state encoding, for debug.

Function
REQ-022 The FSM SHALL have the states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL and TRAP.
REQ-023 FETCH: iord=0, alu_src_a=0, alu_src_b=2, alu_ctrl=ADD, result_src=2; ir_write and pc_write pulse only in the last latency cycle, then the FSM goes to DECODE.
REQ-024 A 4-bit wait counter SHALL count 0..MEM_LATENCY-1 in FETCH, MEM_RD and MEM_WR, clear on state exit, and hold the state until it reaches MEM_LATENCY-1; with MEM_LATENCY=1 each access takes exactly one cycle.
REQ-025 DECODE: alu_src_a=1, alu_src_b=1, alu_ctrl=ADD (branch target into ALUOut); next state by opcode: 0000011/0100011 -> MEM_ADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, 1101111 -> JAL, any other -> TRAP.
REQ-026 MEM_ADR: alu_src_a=2, alu_src_b=1, ADD; next state MEM_RD for opcode 0000011, MEM_WR for 0100011.
REQ-027 MEM_RD: iord=1; after the latency count, next state MEM_WB.
REQ-028 MEM_WB: result_src=1, reg_write=1; next state FETCH.
REQ-029 MEM_WR: iord=1; mem_write is high in every latency cycle; after the count, next state FETCH.
REQ-030 EXEC_R: alu_src_a=2, alu_src_b=0; alu_ctrl from funct3 and funct7_5. EXEC_I: same with alu_src_b=1; funct7_5 is honoured only for shifts. Both go to ALU_WB.
REQ-031 ALU_WB: result_src=0, reg_write=1; next state FETCH.
REQ-032 BRANCH: alu_src_a=2, alu_src_b=0, SUB, result_src=0; pc_write = zero for funct3=000 and = !zero for funct3=001; next state FETCH; any other funct3 -> TRAP.
REQ-033 JAL: alu_src_a=1, alu_src_b=2, result_src=0, pc_write=1, reg_write=1 (rd = old PC + PC_INCREMENT); next state FETCH.
REQ-034 TRAP: illegal=1 and all enables 0; the FSM stays in TRAP until reset.
REQ-035 Outputs SHALL be Moore (decoded from state and counter only), except pc_write in BRANCH, which also depends on zero.
REQ-036 Every enable output (pc_write, ir_write, reg_write, mem_write) SHALL be 0 in any state where it is not listed above.

Reset
REQ-037 When reset=1 at a clock edge: state=FETCH, wait counter=0, illegal=0; this holds mid-access too, and no partial write is completed.
REQ-038 Post-reset outputs: all enables 0 until the FETCH count completes; iord=0.

Structure
REQ-039 A shared package SHALL hold the state enum, the opcode constants, the alu_ctrl codes and the mux select codes.
REQ-040 ALU-control decode (funct3, funct7_5, class -> alu_ctrl) SHALL be the single sub-module alu_decoder.

Verification
REQ-041 MEM_LATENCY=1, opcode 0110011 funct3 000 funct7_5 1 -> states FETCH, DECODE, EXEC_R (alu_ctrl=SUB), ALU_WB; reg_write high one cycle; 4 cycles total.
REQ-042 MEM_LATENCY=3, load 0000011 -> FETCH 3 cycles with ir_write only in the 3rd; MEM_RD 3 cycles; 9 cycles total.
REQ-043 MEM_LATENCY=2, store -> mem_write high exactly 2 cycles with iord=1.
REQ-044 Branch 1100011 funct3 001 with zero=1 -> pc_write 0; repeat with zero=0 -> pc_write 1.
REQ-045 Opcode 1111111 -> TRAP, illegal=1 persists for 20 cycles; reset -> FETCH with illegal=0.
REQ-046 Reset asserted in the 2nd cycle of MEM_WR with MEM_LATENCY=3 -> next cycle state=FETCH and mem_write=0.
